// File: rtl/types_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// types_pkg : shared register-file widths and elaboration helpers
// Rev 1.0
// ---------------------------------------------------------------------------
package types_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_scoreboard : per-register busy bits, set at issue and cleared at writeback
// Rev 1.0
// ---------------------------------------------------------------------------
module rf_scoreboard #(
  parameter int NREGS = 32,
  parameter int NWR   = 1,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (rsv_en) w_set[rsv_addr] = 1'b1;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) w_clr[wr_addr[j*AW +: AW]] = 1'b1;
    end
    w_set[0] = 1'b0;
    w_clr[0] = 1'b0;
  end

  // A new reservation outranks a same-cycle writeback: the new producer owns the register.
  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_set | (r_busy & ~w_clr);
  end

  assign busy_vec = r_busy;

endmodule
`default_nettype wire

// File: rtl/regfile_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_pipe : multi-port register file with optional write bypass and busy scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
module regfile_pipe
  import types_pkg::*;
#(
  parameter int XLEN   = types_pkg::XLEN,
  parameter int NREGS  = types_pkg::NREGS,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRD*$clog2(NREGS)-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]      rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR*$clog2(NREGS)-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0]      wr_data,
  input  logic                     rsv_en,
  input  logic [$clog2(NREGS)-1:0] rsv_addr,
  output logic [NREGS-1:0]         busy_vec
);

  localparam int AW = $clog2(NREGS);

  if (NWR < 1 || NWR > 2) begin : g_bad_nwr
    $error("regfile_pipe: NWR must be 1 or 2");
  end
  if (!is_pow2(NREGS)) begin : g_bad_nregs
    $error("regfile_pipe: NREGS must be a power of two, at least 2");
  end
  if (NRD < 1) begin : g_bad_nrd
    $error("regfile_pipe: NRD must be at least 1");
  end

  logic [XLEN-1:0] r_regs [NREGS];

  // Later ports overwrite earlier ones, so port 1 wins on an address clash.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != '0))
          r_regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy_vec (busy_vec)
  );

  logic [AW-1:0]   w_ra;
  logic [XLEN-1:0] w_rd;
  logic            w_hit;
  logic            w_rb;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    w_ra    = '0;
    w_rd    = '0;
    w_hit   = 1'b0;
    w_rb    = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      w_ra  = rd_addr[i*AW +: AW];
      w_rd  = r_regs[w_ra];
      w_hit = 1'b0;
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == w_ra)) begin
            w_rd  = wr_data[j*XLEN +: XLEN];
            w_hit = 1'b1;
          end
        end
      end
      if (w_ra == '0) begin
        w_rd  = '0;
        w_hit = 1'b0;
      end
      // A forwarded write retires the producer unless a new one is reserved this cycle.
      w_rb = busy_vec[w_ra];
      if (w_hit && !(rsv_en && (rsv_addr == w_ra))) w_rb = 1'b0;
      rd_data[i*XLEN +: XLEN] = w_rd;
      rd_busy[i]              = w_rb;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_regfile_pipe : scoreboard bench, bypassing dual-write DUT beside a non-bypass single-write DUT
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_regfile_pipe;

  localparam int AW = 5;

  typedef struct packed {
    logic [2:0]  kind;
    logic [0:0]  port;
    logic [31:0] val;
  } exp_t;

  localparam logic [2:0] K_A_RD = 3'd0, K_A_RB = 3'd1, K_A_BV = 3'd2,
                         K_B_RD = 3'd3, K_B_BV = 3'd4, K_B_RB = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;

  logic [63:0] a_rd_data, b_rd_data;
  logic [1:0]  a_rd_busy, b_rd_busy;
  logic [31:0] a_busy, b_busy;

  exp_t  q_exp[$];
  string q_name[$];
  int    n_vec = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  regfile_pipe #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(a_busy)
  );

  regfile_pipe #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(wr_en[0:0]), .wr_addr(wr_addr[4:0]), .wr_data(wr_data[31:0]),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(b_busy)
  );

  task automatic expect_v(input logic [2:0] k, input logic p, input logic [31:0] v, input string nm);
    exp_t e;
    e.kind = k;
    e.port = p;
    e.val  = v;
    q_exp.push_back(e);
    q_name.push_back(nm);
  endtask

  // Drive one cycle's inputs just after the active edge.
  task automatic drive(input logic r,
                       input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic rv, input logic [4:0] ra,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    rst      = r;
    wr_en    = {we1, we0};
    wr_addr  = {wa1, wa0};
    wr_data  = {wd1, wd0};
    rsv_en   = rv;
    rsv_addr = ra;
    rd_addr  = {ra1, ra0};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle's outputs are valid, so drain all pending expectations at negedge.
  always @(negedge clk) begin
    while (q_exp.size() > 0) begin
      exp_t        e;
      string       nm;
      logic [31:0] act;
      e   = q_exp.pop_front();
      nm  = q_name.pop_front();
      act = '0;
      case (e.kind)
        K_A_RD:  act = a_rd_data[e.port*32 +: 32];
        K_A_RB:  act = {31'd0, a_rd_busy[e.port]};
        K_A_BV:  act = a_busy;
        K_B_RD:  act = b_rd_data[e.port*32 +: 32];
        K_B_BV:  act = b_busy;
        default: act = {31'd0, b_rd_busy[e.port]};
      endcase
      n_vec++;
      if (act !== e.val) begin
        n_err++;
        $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, e.val);
      end
    end
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    expect_v(K_A_RD, 0, 32'h0, "reset_a_rd");
    expect_v(K_A_BV, 0, 32'h0, "reset_a_busy");
    expect_v(K_B_RD, 0, 32'h0, "reset_b_rd");
    expect_v(K_B_BV, 0, 32'h0, "reset_b_busy");
    next_cycle();

    drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
    expect_v(K_A_RD, 0, 32'hDEADBEEF, "r5_bypass_a");
    expect_v(K_B_RD, 0, 32'h0, "r5_nobypass_b");
    next_cycle();

    drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
    expect_v(K_A_RD, 0, 32'hDEADBEEF, "r5_stored_a");
    expect_v(K_B_RD, 0, 32'hDEADBEEF, "r5_stored_b");
    expect_v(K_A_BV, 0, 32'h0, "rsv_not_yet");
    next_cycle();

    drive(1, 1, 5, 32'h1, 0, 0, 0, 0, 0, 5, 0);
    expect_v(K_A_BV, 0, 32'h0000_0020, "r5_busy_pre_rst");
    expect_v(K_A_RD, 0, 32'h1, "rst_cycle_bypass_a");
    expect_v(K_A_RB, 0, 32'h0, "rst_cycle_rdbusy_fwd");
    expect_v(K_B_RD, 0, 32'hDEADBEEF, "rst_cycle_b_old");
    next_cycle();

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    expect_v(K_A_RD, 0, 32'h0, "post_rst_r5_a");
    expect_v(K_B_RD, 0, 32'h0, "post_rst_r5_b");
    expect_v(K_A_BV, 0, 32'h0, "post_rst_busy_a");
    expect_v(K_B_BV, 0, 32'h0, "post_rst_busy_b");
    next_cycle();

    drive(0, 1, 0, 32'h1234, 1, 0, 32'h1234, 1, 0, 0, 0);
    expect_v(K_A_RD, 0, 32'h0, "x0_bypass_a");
    expect_v(K_A_RB, 0, 32'h0, "x0_rdbusy_a");
    expect_v(K_B_RD, 0, 32'h0, "x0_b");
    next_cycle();

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_v(K_A_RD, 0, 32'h0, "x0_stored_a");
    expect_v(K_A_BV, 0, 32'h0, "x0_busy_a");
    expect_v(K_B_BV, 0, 32'h0, "x0_busy_b");
    next_cycle();

    drive(0, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 7, 0);
    expect_v(K_A_RD, 0, 32'hA5A5A5A5, "r7_bypass_a");
    expect_v(K_B_RD, 0, 32'h0, "r7_old_b");
    next_cycle();

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    expect_v(K_A_RD, 0, 32'hA5A5A5A5, "r7_stored_a");
    expect_v(K_B_RD, 0, 32'hA5A5A5A5, "r7_next_b");
    expect_v(K_A_BV, 0, 32'h0, "r7_nonbusy_write");
    next_cycle();

    drive(0, 1, 3, 32'h11, 1, 3, 32'h22, 0, 0, 3, 7);
    expect_v(K_A_RD, 0, 32'h22, "dual_bypass_p1_wins");
    expect_v(K_A_RD, 1, 32'hA5A5A5A5, "dual_other_port");
    expect_v(K_B_RD, 0, 32'h0, "dual_old_b");
    next_cycle();

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 7);
    expect_v(K_A_RD, 0, 32'h22, "dual_stored_p1_wins");
    expect_v(K_B_RD, 0, 32'h11, "single_stored_b");
    next_cycle();

    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
    expect_v(K_A_RB, 1, 32'h0, "r9_rsv_same_cycle");
    expect_v(K_A_BV, 0, 32'h0, "r9_bv_same_cycle");
    next_cycle();

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    expect_v(K_A_RB, 1, 32'h1, "r9_busy_a");
    expect_v(K_A_BV, 0, 32'h0000_0200, "r9_bv_a");
    expect_v(K_B_BV, 0, 32'h0000_0200, "r9_bv_b");
    expect_v(K_B_RB, 1, 32'h1, "r9_busy_b");
    next_cycle();

    drive(0, 1, 9, 32'h99, 0, 0, 0, 1, 9, 0, 9);
    expect_v(K_A_RB, 1, 32'h1, "r9_wr_rsv_rdbusy");
    expect_v(K_A_RD, 1, 32'h99, "r9_wr_rsv_bypass");
    next_cycle();

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    expect_v(K_A_RB, 1, 32'h1, "r9_set_beats_clr");
    expect_v(K_A_BV, 0, 32'h0000_0200, "r9_bv_set_beats_clr");
    expect_v(K_A_RD, 1, 32'h99, "r9_stored");
    next_cycle();

    drive(0, 0, 0, 0, 1, 9, 32'h9A, 0, 0, 0, 9);
    expect_v(K_A_RB, 1, 32'h0, "r9_wb_fwd_rdbusy");
    expect_v(K_A_BV, 0, 32'h0000_0200, "r9_wb_bv_pending");
    next_cycle();

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    expect_v(K_A_RB, 1, 32'h0, "r9_released");
    expect_v(K_A_BV, 0, 32'h0, "r9_bv_released");
    expect_v(K_A_RD, 1, 32'h9A, "r9_port1_data");
    expect_v(K_B_RD, 1, 32'h99, "r9_b_unchanged");
    expect_v(K_B_BV, 0, 32'h0000_0200, "r9_b_still_busy");
    next_cycle();

    drive(0, 0, 0, 0, 0, 0, 0, 1, 4, 4, 6);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 6, 4, 6);
    expect_v(K_A_BV, 0, 32'h0000_0010, "r4_reserved");
    next_cycle();

    drive(0, 0, 0, 0, 0, 0, 0, 1, 6, 4, 6);
    expect_v(K_A_BV, 0, 32'h0000_0050, "r4_r6_reserved");
    expect_v(K_B_BV, 0, 32'h0000_0250, "r4_r6_r9_b");
    next_cycle();

    drive(1, 1, 4, 32'h55, 0, 0, 0, 0, 0, 4, 6);
    expect_v(K_A_RD, 0, 32'h55, "mid_rst_bypass");
    expect_v(K_A_RB, 1, 32'h1, "r6_still_busy");
    expect_v(K_A_BV, 0, 32'h0000_0050, "r6_rerserve_kept");
    next_cycle();

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 6);
    expect_v(K_A_RD, 0, 32'h0, "mid_rst_r4_a");
    expect_v(K_A_BV, 0, 32'h0, "mid_rst_busy_a");
    expect_v(K_B_RD, 0, 32'h0, "mid_rst_r4_b");
    expect_v(K_B_BV, 0, 32'h0, "mid_rst_busy_b");
    next_cycle();

    @(negedge clk);
    #1;
    if (q_exp.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, required 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
